conv_line_engine: RTL and testbench



---
 rtl/conv_line_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_conv_line_engine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_line_engine.sv
// Symmetric (2R+1)-tap 1-D line convolution over a source SRAM image, with an
// optionally transposed write to a destination SRAM (two passes give a 2-D blur).
// Latency: first write at s+1+2R+RD_LAT+2; one write/cycle, 2R-cycle gap between rows.
// Backpressure: none. Source must return data RD_LAT cycles after src_re; the
// destination must accept one write per cycle. start is ignored while busy.
//
// Ports: clk/rstn (async active-low); start + sampled config (nrows, ncols,
// transpose, border_mode, coef); status busy/done/err; source read port
// src_re/src_row/src_col/src_rdata; destination write port dst_we/dst_row/
// dst_col/dst_wdata (address/data forced to 0 when dst_we=0).
module conv_line_engine #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int R      = 5,
  parameter int CW     = 8,
  parameter int SHIFT  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [AW-1:0]         nrows,
  input  logic [AW-1:0]         ncols,
  input  logic                  transpose,
  input  logic [1:0]            border_mode,
  input  logic [(R+1)*CW-1:0]   coef,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  src_re,
  output logic [AW-1:0]         src_row,
  output logic [AW-1:0]         src_col,
  input  logic [DW-1:0]         src_rdata,
  output logic                  dst_we,
  output logic [AW-1:0]         dst_row,
  output logic [AW-1:0]         dst_col,
  output logic [DW-1:0]         dst_wdata
);

  localparam int TAPS = 2 * R + 1;
  // Slot index within a row runs 0 .. ncols-1+2R (virtual column + R).
  localparam int VW   = AW + 2;
  localparam int SW   = DW + CW + $clog2(TAPS);
  localparam int RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [SW:0] RND  = (SHIFT > 0) ? ((SW+1)'(1) << RSH) : '0;
  localparam logic [SW:0] SATV = (SW+1)'({DW{1'b1}});

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN, S_ERR} state_t;

  // Per-slot tag travelling alongside the SRAM read.
  typedef struct packed {
    logic          vld;
    logic          zero;   // out-of-range slot under zero border: inject 0
    logic [AW-1:0] row;
    logic [VW-1:0] idx;
  } tag_t;

  state_t                state;
  logic [AW-1:0]         nrows_q, ncols_q;
  logic                  transpose_q;
  logic [1:0]            mode_q;
  logic [(R+1)*CW-1:0]   coef_q;
  logic [AW-1:0]         row_cnt;
  logic [VW-1:0]         idx_cnt;
  logic [VW-1:0]         idx_last;
  logic [AW:0]           slot_next;
  logic [AW:0]           slot_first;
  logic                  dst_last;

  tag_t                  tag_in;
  tag_t                  tag_q [RD_LAT];
  logic [DW-1:0]         win [TAPS];
  logic                  wt_vld;
  logic [AW-1:0]         wt_row;
  logic [VW-1:0]         wt_idx;

  logic [SW-1:0]         sum;
  logic [SW:0]           rnd_sum;
  logic [SW:0]           shifted;
  logic [DW-1:0]         res;
  logic [AW-1:0]         out_j;

  // Maps a slot index to {read_enable, physical column} for the border mode.
  function automatic logic [AW:0] slot_col(input logic [VW-1:0] idx,
                                           input logic [AW-1:0] n,
                                           input logic [1:0]    mode);
    logic signed [VW:0] v;
    logic signed [VW:0] nm1;
    logic [AW:0]        res_c;
    v     = $signed({1'b0, idx}) - $signed((VW+1)'(R));
    nm1   = $signed((VW+1)'(n)) - $signed((VW+1)'(1));
    res_c = {1'b1, AW'(v)};
    if (v < 0) begin
      case (mode)
        2'd0:    res_c = {1'b1, AW'(-v)};
        2'd1:    res_c = {1'b1, {AW{1'b0}}};
        default: res_c = '0;
      endcase
    end else if (v > nm1) begin
      case (mode)
        2'd0:    res_c = {1'b1, AW'(nm1 + nm1 - v)};
        2'd1:    res_c = {1'b1, AW'(nm1)};
        default: res_c = '0;
      endcase
    end
    return res_c;
  endfunction

  assign idx_last   = VW'(ncols_q) + VW'(2 * R - 1);
  assign slot_next  = slot_col((idx_cnt == idx_last) ? '0 : idx_cnt + 1'b1, ncols_q, mode_q);
  assign slot_first = slot_col('0, ncols, border_mode);

  // Control FSM; all status and source-port outputs are registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      nrows_q     <= '0;
      ncols_q     <= '0;
      transpose_q <= 1'b0;
      mode_q      <= 2'd0;
      coef_q      <= '0;
      row_cnt     <= '0;
      idx_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      src_re      <= 1'b0;
      src_row     <= '0;
      src_col     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            nrows_q     <= nrows;
            ncols_q     <= ncols;
            transpose_q <= transpose;
            mode_q      <= border_mode;
            coef_q      <= coef;
            err         <= 1'b0;
            row_cnt     <= '0;
            idx_cnt     <= '0;
            if (nrows == '0 || ncols == '0 || {1'b0, ncols} <= (AW+1)'(R)) begin
              state <= S_ERR;
              err   <= 1'b1;
              done  <= 1'b1;
            end else begin
              state   <= S_RUN;
              busy    <= 1'b1;
              src_re  <= slot_first[AW];
              src_col <= slot_first[AW-1:0];
              src_row <= '0;
            end
          end
        end
        S_RUN: begin
          if (idx_cnt == idx_last && row_cnt == nrows_q - 1'b1) begin
            state   <= S_DRAIN;
            src_re  <= 1'b0;
            src_row <= '0;
            src_col <= '0;
          end else begin
            if (idx_cnt == idx_last) begin
              idx_cnt <= '0;
              row_cnt <= row_cnt + 1'b1;
              src_row <= row_cnt + 1'b1;
            end else begin
              idx_cnt <= idx_cnt + 1'b1;
              src_row <= row_cnt;
            end
            src_re  <= slot_next[AW];
            src_col <= slot_next[AW-1:0];
          end
        end
        S_DRAIN: begin
          if (dst_we && dst_last) begin
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_FIN:   state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tag_in      = '0;
    tag_in.vld  = (state == S_RUN);
    tag_in.zero = (state == S_RUN) && !src_re;
    tag_in.row  = row_cnt;
    tag_in.idx  = idx_cnt;
  end

  // Kernel sum over the window; win[R] is the centre, win[0] the newest pixel.
  always_comb begin
    sum = SW'(coef_q[CW-1:0]) * SW'(win[R]);
    for (int k = 1; k <= R; k++) begin
      sum = sum + SW'(coef_q[k*CW +: CW]) * (SW'(win[R-k]) + SW'(win[R+k]));
    end
    rnd_sum = {1'b0, sum} + RND;
    shifted = rnd_sum >> SHIFT;
    res     = (shifted > SATV) ? {DW{1'b1}} : DW'(shifted);
    out_j   = AW'(wt_idx - VW'(2 * R));
  end

  // Read-tag pipeline, window shift and output register stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
      for (int k = 0; k < TAPS; k++)   win[k]   <= '0;
      wt_vld    <= 1'b0;
      wt_row    <= '0;
      wt_idx    <= '0;
      dst_we    <= 1'b0;
      dst_row   <= '0;
      dst_col   <= '0;
      dst_wdata <= '0;
      dst_last  <= 1'b0;
    end else begin
      tag_q[0] <= tag_in;
      for (int k = 1; k < RD_LAT; k++) tag_q[k] <= tag_q[k-1];

      wt_vld <= tag_q[RD_LAT-1].vld;
      wt_row <= tag_q[RD_LAT-1].row;
      wt_idx <= tag_q[RD_LAT-1].idx;
      if (tag_q[RD_LAT-1].vld) begin
        win[0] <= tag_q[RD_LAT-1].zero ? '0 : src_rdata;
        for (int k = 1; k < TAPS; k++) win[k] <= win[k-1];
      end

      // Slots are contiguous within a row, so once 2R+1 slots of a row have
      // arrived the window never straddles two rows.
      if (wt_vld && wt_idx >= VW'(2 * R)) begin
        dst_we    <= 1'b1;
        dst_row   <= transpose_q ? out_j : wt_row;
        dst_col   <= transpose_q ? wt_row : out_j;
        dst_wdata <= res;
        dst_last  <= (wt_row == nrows_q - 1'b1) && (out_j == ncols_q - 1'b1);
      end else begin
        dst_we    <= 1'b0;
        dst_row   <= '0;
        dst_col   <= '0;
        dst_wdata <= '0;
        dst_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_line_engine.sv
module tb_conv_line_engine;
  localparam int DW = 8, AW = 8, R = 5, CW = 9, SHIFT = 8, RD_LAT = 2;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
  logic [AW-1:0]       nrows = '0, ncols = '0;
  logic                transpose = 1'b0;
  logic [1:0]          border_mode = 2'd0;
  logic [(R+1)*CW-1:0] coef = '0;
  logic                busy, done, err, src_re, dst_we;
  logic [AW-1:0]       src_row, src_col, dst_row, dst_col;
  logic [DW-1:0]       src_rdata, dst_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;

  conv_line_engine #(.DW(DW), .AW(AW), .R(R), .CW(CW), .SHIFT(SHIFT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .nrows(nrows), .ncols(ncols),
    .transpose(transpose), .border_mode(border_mode), .coef(coef),
    .busy(busy), .done(done), .err(err),
    .src_re(src_re), .src_row(src_row), .src_col(src_col), .src_rdata(src_rdata),
    .dst_we(dst_we), .dst_row(dst_row), .dst_col(dst_col), .dst_wdata(dst_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source SRAM model with RD_LAT-cycle read latency.
  logic [7:0]    src_mem [16][16];
  logic [AW-1:0] p_row [RD_LAT];
  logic [AW-1:0] p_col [RD_LAT];
  always @(posedge clk) begin
    p_row[0] <= src_row;
    p_col[0] <= src_col;
    for (int k = 1; k < RD_LAT; k++) begin
      p_row[k] <= p_row[k-1];
      p_col[k] <= p_col[k-1];
    end
  end
  assign src_rdata = src_mem[p_row[RD_LAT-1][3:0]][p_col[RD_LAT-1][3:0]];

  // Activity log, sampled mid-cycle.
  int wr_row_q[$], wr_col_q[$], wr_dat_q[$], wr_cyc_q[$];
  int rd_cnt, done_cnt, done_cyc, busy_last, first_rd;
  always @(negedge clk) begin
    if (dst_we) begin
      wr_row_q.push_back(int'(dst_row));
      wr_col_q.push_back(int'(dst_col));
      wr_dat_q.push_back(int'(dst_wdata));
      wr_cyc_q.push_back(cyc);
    end
    if (src_re) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_last = cyc;
  end

  task automatic clear_logs();
    wr_row_q.delete(); wr_col_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete();
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; busy_last = -1; first_rd = -1;
  endtask

  task automatic set_coef(input int c0, input int ck, input int c5);
    coef = '0;
    coef[CW-1:0] = CW'(c0);
    for (int k = 1; k < R; k++) coef[k*CW +: CW] = CW'(ck);
    coef[R*CW +: CW] = CW'(c5);
  endtask

  // Returns in the cycle after the accepting edge (spec cycle s+1).
  task automatic start_op(input int nr, input int nc, input logic tr, input logic [1:0] bm);
    @(posedge clk); #1;
    clear_logs();
    nrows = AW'(nr); ncols = AW'(nc); transpose = tr; border_mode = bm;
    start = 1'b1;
    @(posedge clk); #1;
    s_cyc = cyc - 1;  // period in which start was sampled high
    start = 1'b0;
  endtask

  task automatic wait_done(input bit extra_start);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 600) begin
      @(negedge clk);
      if (extra_start && n == 4) begin
        start = 1'b1; nrows = 8'd1; ncols = 8'd20; transpose = 1'b0;
      end
      if (extra_start && n == 5) start = 1'b0;
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles, required a done pulse", n);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    checks++;
    if ({busy, done, err, src_re, dst_we, src_row, src_col, dst_row, dst_col, dst_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {busy, done, err, src_re, dst_we, src_row, src_col, dst_row, dst_col, dst_wdata});
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_identity();
    int nw, last;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) src_mem[r][c] = 8'(r * 16 + c);
    set_coef(256, 0, 0);
    start_op(3, 8, 1'b0, 2'd0);
    wait_done(1'b0);
    nw = wr_cyc_q.size();
    checks++;
    if (nw != 24) begin errors++; $display("FAIL ident_count: got %0d writes, required 24", nw); end
    for (int i = 0; i < nw && i < 24; i++) begin
      checks++;
      if (wr_row_q[i] !== i / 8 || wr_col_q[i] !== i % 8 || wr_dat_q[i] !== (i / 8) * 16 + i % 8) begin
        errors++;
        $display("FAIL ident_write[%0d]: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d", i,
                 wr_row_q[i], wr_col_q[i], wr_dat_q[i], i / 8, i % 8, (i / 8) * 16 + i % 8);
      end
    end
    if (nw == 24) begin
      last = wr_cyc_q[23];
      checks++;
      if (first_rd - s_cyc != 1) begin errors++; $display("FAIL ident_first_read: got s+%0d, required s+1", first_rd - s_cyc); end
      checks++;
      if (wr_cyc_q[0] - s_cyc != 15) begin errors++; $display("FAIL ident_first_write: got s+%0d, required s+15", wr_cyc_q[0] - s_cyc); end
      checks++;
      if (wr_cyc_q[1] - wr_cyc_q[0] != 1) begin errors++; $display("FAIL ident_steady: got spacing %0d, required 1", wr_cyc_q[1] - wr_cyc_q[0]); end
      checks++;
      if (wr_cyc_q[8] - wr_cyc_q[7] != 2 * R + 1) begin errors++; $display("FAIL ident_row_gap: got spacing %0d, required %0d", wr_cyc_q[8] - wr_cyc_q[7], 2 * R + 1); end
      checks++;
      if (busy_last != last) begin errors++; $display("FAIL ident_busy_end: got %0d, required %0d", busy_last, last); end
      checks++;
      if (done_cyc != last + 1) begin errors++; $display("FAIL ident_done_cycle: got %0d, required %0d", done_cyc, last + 1); end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL ident_done_pulses: got %0d, required 1", done_cnt); end
    checks++;
    if (rd_cnt != 54) begin errors++; $display("FAIL ident_reads: got %0d, required 54", rd_cnt); end
  endtask

  task automatic test_zero_border();
    for (int c = 0; c < 16; c++) src_mem[0][c] = 8'd100;
    set_coef(96, 16, 16);
    start_op(1, 12, 1'b0, 2'd2);
    wait_done(1'b0);
    checks++;
    if (wr_dat_q.size() != 12) begin
      errors++; $display("FAIL zero_count: got %0d writes, required 12", wr_dat_q.size());
    end else begin
      checks++;
      if (wr_dat_q[0] !== 69) begin errors++; $display("FAIL zero_col0: got %0d, required 69", wr_dat_q[0]); end
      checks++;
      if (wr_dat_q[5] !== 100 || wr_dat_q[6] !== 100) begin errors++; $display("FAIL zero_mid: got %0d/%0d, required 100/100", wr_dat_q[5], wr_dat_q[6]); end
      checks++;
      if (wr_dat_q[11] !== 69) begin errors++; $display("FAIL zero_col11: got %0d, required 69", wr_dat_q[11]); end
    end
    checks++;
    if (rd_cnt != 12) begin errors++; $display("FAIL zero_reads: got %0d, required 12", rd_cnt); end
  endtask

  task automatic test_reflect_replicate();
    for (int c = 0; c < 16; c++) src_mem[0][c] = 8'(10 * c);
    set_coef(0, 0, 128);
    start_op(1, 8, 1'b0, 2'd0);
    wait_done(1'b0);
    checks++;
    if (wr_dat_q.size() != 8 || wr_dat_q[0] !== 50 || wr_dat_q[7] !== 20) begin
      errors++; $display("FAIL reflect_edges: got %0d writes, col0=%0d col7=%0d, required 8, 50, 20",
                         wr_dat_q.size(), wr_dat_q.size() > 0 ? wr_dat_q[0] : -1, wr_dat_q.size() > 7 ? wr_dat_q[7] : -1);
    end
    start_op(1, 8, 1'b0, 2'd1);
    wait_done(1'b0);
    checks++;
    if (wr_dat_q.size() != 8 || wr_dat_q[0] !== 25 || wr_dat_q[7] !== 45) begin
      errors++; $display("FAIL replicate_edges: got %0d writes, col0=%0d col7=%0d, required 8, 25, 45",
                         wr_dat_q.size(), wr_dat_q.size() > 0 ? wr_dat_q[0] : -1, wr_dat_q.size() > 7 ? wr_dat_q[7] : -1);
    end
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) src_mem[r][c] = 8'd255;
    set_coef(255, 255, 255);
    start_op(2, 6, 1'b0, 2'd0);
    wait_done(1'b0);
    checks++;
    if (wr_dat_q.size() != 12) begin errors++; $display("FAIL sat_count: got %0d writes, required 12", wr_dat_q.size()); end
    for (int i = 0; i < wr_dat_q.size(); i++) begin
      checks++;
      if (wr_dat_q[i] !== 255) begin errors++; $display("FAIL sat_write[%0d]: got %0d, required 255", i, wr_dat_q[i]); end
    end
  endtask

  task automatic test_transpose_latency();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) src_mem[r][c] = 8'(r * 16 + c);
    set_coef(256, 0, 0);
    start_op(2, 6, 1'b1, 2'd0);
    wait_done(1'b1);  // also pulses start with a different config while busy
    checks++;
    if (wr_cyc_q.size() != 12) begin
      errors++; $display("FAIL tr_count: got %0d writes, required 12", wr_cyc_q.size());
    end else begin
      checks++;
      if (wr_cyc_q[0] - s_cyc != 15 || wr_row_q[0] !== 0 || wr_col_q[0] !== 0) begin
        errors++; $display("FAIL tr_first: got s+%0d at (%0d,%0d), required s+15 at (0,0)",
                           wr_cyc_q[0] - s_cyc, wr_row_q[0], wr_col_q[0]);
      end
      checks++;
      if (wr_row_q[1] !== 1 || wr_col_q[1] !== 0 || wr_dat_q[1] !== 1) begin
        errors++; $display("FAIL tr_px01: got (%0d,%0d)=%0d, required (1,0)=1", wr_row_q[1], wr_col_q[1], wr_dat_q[1]);
      end
      checks++;
      if (wr_row_q[9] !== 3 || wr_col_q[9] !== 1 || wr_dat_q[9] !== 19) begin
        errors++; $display("FAIL tr_px13: got (%0d,%0d)=%0d, required (3,1)=19", wr_row_q[9], wr_col_q[9], wr_dat_q[9]);
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL tr_done_pulses: got %0d, required 1", done_cnt); end
    nrows = 8'd0;  // leave a harmless config on the inputs
  endtask

  task automatic test_error();
    set_coef(256, 0, 0);
    start_op(1, 5, 1'b0, 2'd0);
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL err_at_s1: got done=%b err=%b busy=%b, required 1 1 0", done, err, busy);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rd_cnt != 0 || wr_cyc_q.size() != 0 || done_cnt != 1) begin
      errors++; $display("FAIL err_activity: got reads=%0d writes=%0d dones=%0d, required 0 0 1",
                         rd_cnt, wr_cyc_q.size(), done_cnt);
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, required 1", err); end
  endtask

  task automatic test_reset_mid();
    int nw, nr;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) src_mem[r][c] = 8'(r * 16 + c);
    set_coef(256, 0, 0);
    start_op(3, 8, 1'b0, 2'd0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_status: got err=%b busy=%b, required 0 1", err, busy); end
    repeat (20) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, src_re, dst_we, src_row, src_col, dst_row, dst_col, dst_wdata} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %h, required 0",
                         {busy, done, err, src_re, dst_we, src_row, src_col, dst_row, dst_col, dst_wdata});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    nw = wr_cyc_q.size();
    nr = rd_cnt;
    repeat (60) @(negedge clk);
    checks++;
    if (wr_cyc_q.size() != nw || rd_cnt != nr || busy !== 1'b0 || done_cnt != 0) begin
      errors++; $display("FAIL midreset_quiet: got writes+%0d reads+%0d busy=%b dones=%0d, required 0 0 0 0",
                         wr_cyc_q.size() - nw, rd_cnt - nr, busy, done_cnt);
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_identity();
    test_zero_border();
    test_reflect_replicate();
    test_saturation();
    test_transpose_latency();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
